// File: rtl/ring_shift_sched.sv
// Scheduler for the serial LED shift ring: it loads a pattern, then issues tick-driven or step-driven shifts.
// Define RING_SCHED_WATCHDOG_EN to add the sticky token-loss detector on serial_in.
module ring_shift_sched #(
  parameter int TICK_DIV = 50_000_000,
  parameter int RING_LEN = 24,
  parameter int POS_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                step_mode,
  input  logic                step,
  input  logic [RING_LEN-1:0] pattern,
  input  logic                serial_in,
  output logic                serial_out,
  output logic                shift_en1,
  output logic                shift_en2,
  output logic [POS_W-1:0]    pos,
  output logic [1:0]          state,
  output logic                busy,
  output logic                token_lost
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(RING_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [RING_LEN-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]    loadCnt_q, loadCnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                tick_q, tick_d;
  logic                sout_q, sout_d;
  logic                stepModePrev_q;
  logic                runTick;

  // The shadow register shifts left once per load pulse, so its MSB is always the next bit to send.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    loadCnt_d = loadCnt_q;
    div_d     = div_q;
    pos_d     = pos_q;
    tick_d    = 1'b0;
    sout_d    = sout_q;
    runTick   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          tick_d    = 1'b1;
          sout_d    = pattern[RING_LEN-1];
          shadow_d  = pattern << 1;
          loadCnt_d = CNT_W'(1);
        end
      end
      LOAD: begin
        if (loadCnt_q == CNT_W'(RING_LEN)) begin
          state_d   = RUN;
          pos_d     = '0;
          div_d     = '0;
          loadCnt_d = '0;
        end else begin
          tick_d    = 1'b1;
          sout_d    = shadow_q[RING_LEN-1];
          shadow_d  = shadow_q << 1;
          loadCnt_d = loadCnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (step_mode) begin
          div_d   = '0;
          runTick = step;
        end else if (stepModePrev_q) begin
          div_d = '0;
        end else if (div_q == DIV_W'(TICK_DIV - 1)) begin
          div_d   = '0;
          runTick = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        if (runTick) begin
          tick_d = 1'b1;
          sout_d = serial_in;
          pos_d  = (pos_q == POS_W'(RING_LEN - 1)) ? '0 : pos_q + POS_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Stop overrides everything, including a tick that would have fired this cycle.
    if (stop) begin
      state_d   = IDLE;
      tick_d    = 1'b0;
      sout_d    = 1'b0;
      pos_d     = '0;
      div_d     = '0;
      loadCnt_d = '0;
      runTick   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shadow_q       <= '0;
      loadCnt_q      <= '0;
      div_q          <= '0;
      pos_q          <= '0;
      tick_q         <= 1'b0;
      sout_q         <= 1'b0;
      stepModePrev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      loadCnt_q      <= loadCnt_d;
      div_q          <= div_d;
      pos_q          <= pos_d;
      tick_q         <= tick_d;
      sout_q         <= sout_d;
      stepModePrev_q <= step_mode;
    end
  end

`ifdef RING_SCHED_WATCHDOG_EN
  logic [CNT_W-1:0] lostCnt_q, lostCnt_d;
  logic             lost_q, lost_d;
  logic             startAccept, enterRun;

  assign startAccept = (state_q == IDLE) && start && !stop;
  assign enterRun    = (state_q == LOAD) && (loadCnt_q == CNT_W'(RING_LEN)) && !stop;

  // Counts ticks since a 1 last came back on serial_in; saturates at RING_LEN.
  always_comb begin
    lostCnt_d = lostCnt_q;
    lost_d    = lost_q;
    if (startAccept) begin
      lost_d    = 1'b0;
      lostCnt_d = '0;
    end
    if (enterRun) begin
      lostCnt_d = '0;
    end
    if (runTick) begin
      if (serial_in) begin
        lostCnt_d = '0;
      end else begin
        if (lostCnt_q < CNT_W'(RING_LEN)) lostCnt_d = lostCnt_q + CNT_W'(1);
        if (lostCnt_q >= CNT_W'(RING_LEN - 1)) lost_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lostCnt_q <= '0;
      lost_q    <= 1'b0;
    end else begin
      lostCnt_q <= lostCnt_d;
      lost_q    <= lost_d;
    end
  end

  assign token_lost = lost_q;
`else
  assign token_lost = 1'b0;
`endif

  assign serial_out = sout_q;
  assign shift_en1  = tick_q;
  assign shift_en2  = tick_q;
  assign pos        = pos_q;
  assign state      = state_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ring_shift_sched.sv
// Directed bench for ring_shift_sched with TICK_DIV=4, RING_LEN=8 and an 8-bit model ring on serial_in.
// Token-loss expectations follow RING_SCHED_WATCHDOG_EN.
module tb_ring_shift_sched;

  localparam int TICK_DIV = 4;
  localparam int RING_LEN = 8;
  localparam int POS_W    = 3;
`ifdef RING_SCHED_WATCHDOG_EN
  localparam logic WD_ON = 1'b1;
`else
  localparam logic WD_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start, stop, stepMode, step;
  logic [RING_LEN-1:0] pattern;
  logic                serialIn, serialOut, shiftEn1, shiftEn2;
  logic [POS_W-1:0]    pos;
  logic [1:0]          state;
  logic                busy, tokenLost;
  logic [7:0]          ringModel = 8'h00;
  logic [7:0]          expSeq;
  int                  compared = 0;
  int                  mismatched = 0;
  int                  pulseSeen = 0;

  ring_shift_sched #(.TICK_DIV(TICK_DIV), .RING_LEN(RING_LEN), .POS_W(POS_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step_mode(stepMode),
    .step(step), .pattern(pattern), .serial_in(serialIn), .serial_out(serialOut),
    .shift_en1(shiftEn1), .shift_en2(shiftEn2), .pos(pos), .state(state),
    .busy(busy), .token_lost(tokenLost)
  );

  always #5 clk = ~clk;

  // Slave chain model: shifts in serial_out whenever shift_en1 is seen on an edge.
  always @(posedge clk) begin
    if (shiftEn1) ringModel <= {ringModel[6:0], serialOut};
  end
  assign serialIn = ringModel[7];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (shiftEn1 || shiftEn2) pulseSeen++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; stepMode = 1'b0; step = 1'b0; pattern = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_en1", shiftEn1, 0);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;

    pulseSeen = 0;
    applyStimulus(20);
    checkOutput("idle_pulses", pulseSeen, 0);
    checkOutput("idle_sout", serialOut, 0);
    checkOutput("idle_pos", pos, 0);
    checkOutput("idle_state", state, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_lost", tokenLost, 0);

    expSeq = 8'b1000_0001;
    pattern = expSeq;
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("load_en1", shiftEn1, 1);
      checkOutput("load_en2", shiftEn2, 1);
      checkOutput("load_sout", serialOut, expSeq[7-k]);
      checkOutput("load_state", state, 1);
    end
    @(posedge clk);
    #1;
    checkOutput("run_state", state, 2);
    checkOutput("run_en1", shiftEn1, 0);
    checkOutput("run_pos", pos, 0);
    checkOutput("run_busy", busy, 1);

    for (int j = 1; j <= 8; j++) begin
      pulseSeen = 0;
      applyStimulus(3);
      checkOutput("tick_gap", pulseSeen, 0);
      @(posedge clk);
      #1;
      checkOutput("tick_en1", shiftEn1, 1);
      checkOutput("tick_en2", shiftEn2, 1);
      checkOutput("tick_pos", pos, j % 8);
      checkOutput("tick_sout", serialOut, expSeq[8-j]);
    end

    stepMode = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      pulseSeen = 0;
      applyStimulus(9);
      checkOutput("step_gap", pulseSeen, 0);
      step = 1'b1;
      @(posedge clk);
      #1;
      step = 1'b0;
      checkOutput("step_en1", shiftEn1, 1);
      checkOutput("step_pos", pos, s);
      checkOutput("step_sout", serialOut, expSeq[8-s]);
    end
    pulseSeen = 0;
    applyStimulus(2);
    checkOutput("step_after", pulseSeen, 0);
    checkOutput("step_final_pos", pos, 3);

    stepMode = 1'b0;
    pulseSeen = 0;
    applyStimulus(4);
    checkOutput("tc_gap", pulseSeen, 0);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    checkOutput("stop_en1", shiftEn1, 0);
    checkOutput("stop_state", state, 0);
    checkOutput("stop_pos", pos, 0);
    checkOutput("stop_sout", serialOut, 0);
    checkOutput("stop_busy", busy, 0);
    pulseSeen = 0;
    applyStimulus(6);
    checkOutput("stop_idle", pulseSeen, 0);

    pattern = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    applyStimulus(8);
    checkOutput("wd_state", state, 2);
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(4);
      checkOutput("wd_tick", shiftEn1, 1);
      checkOutput("wd_lost", tokenLost, (j == 8) ? WD_ON : 1'b0);
    end
    applyStimulus(8);
    checkOutput("wd_held", tokenLost, WD_ON);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    checkOutput("wd_sticky_stop", tokenLost, WD_ON);
    pattern = 8'h81;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("wd_clear", tokenLost, 0);
    checkOutput("restart_state", state, 1);

    applyStimulus(2);
    rst_n = 1'b0;
    #1;
    checkOutput("async_en1", shiftEn1, 0);
    checkOutput("async_state", state, 0);
    checkOutput("async_sout", serialOut, 0);
    checkOutput("async_busy", busy, 0);
    rst_n = 1'b1;
    pulseSeen = 0;
    applyStimulus(5);
    checkOutput("post_rst_pulses", pulseSeen, 0);
    checkOutput("post_rst_state", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ring_shift_sched.md
# ring_shift_sched

Scheduler for the serial LED shift ring (master register chained through slave boards 1 and 2). It runs the ring through three phases. First it loads an initial pattern into the ring at one bit per clock. It then issues the periodic shift-enable ticks that advance the ring. In step mode it issues ticks only on request. It also tracks ring position and, optionally, detects loss of the circulating token.

## Interface
- TICK_DIV, 50_000_000: clk cycles between run-mode ticks (≥2)
- RING_LEN, 24: total bits in the ring (master + all slaves), 2..31
- POS_W, 5: width of position counter, ≥ clog2(RING_LEN)
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; in IDLE, latches `pattern` and begins LOAD
- stop  in  1  pulse; returns to IDLE from any state
- step_mode  in  1  1 = ticks only on `step`; 0 = ticks from divider
- step  in  1  pulse; one tick in RUN when step_mode=1
- pattern  in  RING_LEN  initial ring content; bit RING_LEN-1 shifted first
- serial_in  in  1  ring return from last slave
- serial_out  out  1  ring data to slave 1
- shift_en1, shift_en2  out  1  one-cycle tick to slave chains; always identical
- pos  out  POS_W  ring position, 0..RING_LEN-1
- state  out  2  IDLE=0, LOAD=1, RUN=2
- busy  out  1  state != IDLE
- token_lost  out  1  sticky token-loss flag (see Configuration)

## Operation
- Reset (async assert, sync deassert): state IDLE, shift_en1/2=0, serial_out=0, pos=0, divider=0, load count=0, busy=0, token_lost=0.
- IDLE: no ticks, serial_out=0. `start` moves the block to LOAD and copies `pattern` into a shadow register.
- LOAD: for k=0..RING_LEN-1, assert shift_en1/2 for one cycle each on consecutive cycles, with serial_out=shadow[RING_LEN-1-k] in the same cycle. After the k=RING_LEN-1 pulse, go to RUN with pos=0 and divider=0.
- RUN, step_mode=0: divider counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and issues one tick.
- RUN, step_mode=1: the divider is held at 0. Each `step` issues one tick.
- RUN tick:
  - shift_en1/2=1 for one cycle.
  - serial_out ← serial_in (recirculation).
  - pos ← pos+1, wrapping RING_LEN-1→0.
- A toggle of step_mode in RUN clears the divider.
- `stop` (any state) goes to IDLE on the next edge. It clears serial_out, pos and the divider, and no tick is issued that cycle.
- Priority: stop > tick/load > start.
  - `start` outside IDLE is ignored.
  - `step` is ignored unless RUN with step_mode=1.
  - `step` and a divider terminal count never coincide, because step_mode selects one source.

## Timing
- All outputs are registered. `start` sampled at edge N gives the first LOAD pulse in cycle N+1 and the last in cycle N+RING_LEN. State reads RUN from cycle N+RING_LEN+1.
- Run-mode tick spacing is exactly TICK_DIV cycles. The first tick comes TICK_DIV cycles after RUN is entered.
- Step tick: `step` sampled at edge N gives shift_en high in cycle N+1.
- serial_out changes only on the edge that raises shift_en and is stable while shift_en=1. Slaves sample both on the same edge.
- Reset asserted mid-LOAD or mid-RUN: outputs reach reset values immediately with no partial tick. After release, the block waits for a new `start`.

## Configuration
- RING_SCHED_WATCHDOG_EN defined:
  - In RUN, a tick counter counts ticks since serial_in was last sampled 1 at a tick.
  - When it reaches RING_LEN, token_lost goes high.
  - token_lost is sticky until reset or the next `start`.
  - The counter clears on entering RUN.
- Undefined: token_lost is constant 0 and the counter logic is absent.

## Test plan
Bench parameters: TICK_DIV=4, RING_LEN=8.
- Reset then idle 20 cycles -> shift_en1/2=0, serial_out=0, pos=0, state=0, busy=0.
- start with pattern=8'b1000_0001 -> 8 consecutive shift_en pulses with serial_out sequence 1,0,0,0,0,0,0,1; state=2 on the 9th cycle after start; pos=0.
- In RUN with serial_in tied to a model 8-bit ring -> a tick every 4 cycles; pos sequence 1..7,0; serial_out replays the loaded pattern each revolution.
- step_mode=1, three step pulses 10 cycles apart -> exactly 3 ticks, each 1 cycle after its step; pos=3.
- stop asserted in the same cycle as a divider terminal count -> no tick; state=0 next cycle; pos=0.
- With RING_SCHED_WATCHDOG_EN, pattern=0, serial_in held 0 -> token_lost=1 after the 8th RUN tick and held there; a new start clears it.
